turn_timer_ctrl: RTL and testbench
==================================

// Module: turn_timer_ctrl
// PURPOSE
//   Turn-timeout controller that sits directly downstream of the 8-bit free-running Timer.
//   It consumes timer_out as timer_in and drives the Timer's rst_timer input.
//   Each Timer wrap (256 clk) is one tick; the block counts ticks down per player turn.
//   Outputs: warning when time is low, one-cycle timeout pulse on expiry, current player.
// PARAMETERS
//   TURN_LIMIT  15  ticks allowed per turn; legal range 2..15
//   WARN_AT     5   secs_left value at which WARN is entered; legal range 1..TURN_LIMIT-1
// PORTS
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-low reset (0 = reset)
//   start       in   1  begin/resume game; sampled only in IDLE and EXPIRED
//   move_valid  in   1  1-cycle pulse: current player completed a move
//   timer_in    in   8  count from upstream Timer (timer_out)
//   rst_timer   out  1  registered; clears upstream Timer when 1
//   player      out  1  current player (0/1)
//   secs_left   out  4  ticks remaining in current turn
//   warn        out  1  1 while state == WARN
//   timeout     out  1  1-cycle pulse on expiry
//   state       out  2  IDLE=00 RUN=01 WARN=10 EXPIRED=11
// BEHAVIOUR
//   Reset (rst=0, async, no clock needed):
//     state=IDLE, rst_timer=1, player=0, secs_left=TURN_LIMIT, warn=0, timeout=0.
//   tick = (timer_in == 8'hFF) && (rst_timer == 0), sampled combinationally at the clk edge.
//     Ticks occur every 256 clk while the Timer runs.
//   All outputs are registered; an input sampled at edge k is reflected after edge k.
//   IDLE: rst_timer=1.
//     start -> RUN; secs_left=TURN_LIMIT; rst_timer=0.
//     move_valid is ignored.
//   RUN:
//     tick -> secs_left -= 1; if the new value == WARN_AT, go to WARN.
//   WARN:
//     tick -> secs_left -= 1; if the new value == 0, go to EXPIRED, timeout=1 for one cycle,
//       rst_timer=1.
//   Move (RUN or WARN): move_valid=1 ->
//     player toggles, secs_left=TURN_LIMIT, state=RUN.
//     rst_timer=1 for exactly one cycle; timer_in reads 0 on the following cycle.
//     The next tick comes 256 clk after the clear.
//   EXPIRED: rst_timer=1 held; secs_left holds 0.
//     move_valid is ignored.
//     start -> RUN; player toggles (turn passes); secs_left=TURN_LIMIT; rst_timer=0.
//   Simultaneous events:
//     move_valid and tick in the same cycle: the move wins; no decrement, no timeout.
//     start in RUN or WARN is ignored.
//   secs_left never underflows; no decrement occurs in IDLE or EXPIRED.
//   warn is a registered decode of state; timeout is never asserted for 2 consecutive cycles.
//   Reset asserted mid-turn returns to the reset values immediately.
//     Deassertion takes effect at the next clk edge.
// TESTING (TURN_LIMIT=15, WARN_AT=5, bench instantiates the real Timer)
//   1 Reset -> state=00, rst_timer=1, player=0, secs_left=15, warn=0, timeout=0.
//   2 start, no moves -> secs_left=14 after 256 clk; state=10 after 10 ticks;
//     timeout pulses 1 cycle after 15 ticks; state=11, rst_timer=1.
//   3 move_valid at secs_left=7 -> player=1, secs_left=15, rst_timer high exactly 1 cycle,
//     timer_in=0 on the next cycle.
//   4 In WARN, move_valid on the same cycle as timer_in=FF -> state=01, secs_left=15,
//     no decrement, timeout=0.
//   5 rst pulled low mid-WARN between clk edges -> all outputs at reset values before
//     the next edge.
//   6 In EXPIRED, move_valid ignored (player unchanged); then start -> state=01,
//     player toggled, secs_left=15.

Source files
------------

// File: rtl/turn_timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// turn_timer_ctrl_if
//   Bundles the game-side and Timer-side signals of turn_timer_ctrl.
//   master : drives start / move_valid / timer_in, observes controller outputs
//   slave  : the controller itself
//   Signals:
//     start      begin/resume game (honoured only in IDLE / EXPIRED)
//     move_valid 1-cycle pulse, current player completed a move
//     timer_in   8-bit count from the upstream free-running Timer
//     rst_timer  clears the upstream Timer while 1
//     player     current player (0/1)
//     secs_left  ticks remaining in the current turn
//     warn       1 while in WARN
//     timeout    1-cycle pulse on expiry
//     state      IDLE=00 RUN=01 WARN=10 EXPIRED=11
// -----------------------------------------------------------------------------
interface turn_timer_ctrl_if;
   logic       start;
   logic       move_valid;
   logic [7:0] timer_in;
   logic       rst_timer;
   logic       player;
   logic [3:0] secs_left;
   logic       warn;
   logic       timeout;
   logic [1:0] state;

   modport master (
      output start, move_valid, timer_in,
      input  rst_timer, player, secs_left, warn, timeout, state
   );

   modport slave (
      input  start, move_valid, timer_in,
      output rst_timer, player, secs_left, warn, timeout, state
   );
endinterface

// File: rtl/turn_timer_ctrl.sv
// -----------------------------------------------------------------------------
// turn_timer_ctrl
//   Turn-timeout controller placed directly downstream of an 8-bit free-running
//   Timer. Every Timer wrap (timer_in == FF while the Timer is not held in
//   clear) is one tick; ticks count down the current player's turn.
//   Ports:
//     clk  rising-edge system clock
//     rst  asynchronous, active-low reset
//     bus  turn_timer_ctrl_if.slave (start, move_valid, timer_in in;
//          rst_timer, player, secs_left, warn, timeout, state out)
//   Parameters:
//     TURN_LIMIT ticks per turn (2..15)
//     WARN_AT    secs_left value that enters WARN (1..TURN_LIMIT-1)
// -----------------------------------------------------------------------------
module turn_timer_ctrl #(
   parameter int unsigned TURN_LIMIT = 15,
   parameter int unsigned WARN_AT    = 5
) (
   input  logic                clk,
   input  logic                rst,
   turn_timer_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      WARN    = 2'b10,
      EXPIRED = 2'b11
   } state_t;

   localparam logic [3:0] LIMIT4 = 4'(TURN_LIMIT);
   localparam logic [3:0] WARN4  = 4'(WARN_AT);

   state_t     r_state;
   logic       r_rst_timer;
   logic       r_player;
   logic [3:0] r_secs_left;
   logic       r_warn;
   logic       r_timeout;

   logic       w_tick;
   logic [3:0] w_secs_dec;

   // A wrap only counts while the Timer is actually running; the FF seen in
   // the cycle the clear is applied is stale.
   assign w_tick     = (bus.timer_in == 8'hFF) && !r_rst_timer;
   assign w_secs_dec = r_secs_left - 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_rst_timer <= 1'b1;
         r_player    <= 1'b0;
         r_secs_left <= LIMIT4;
         r_warn      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state     <= RUN;
                  r_secs_left <= LIMIT4;
                  r_rst_timer <= 1'b0;
               end
            end
            RUN, WARN: begin
               // A move outranks a coincident tick: no decrement, no expiry.
               if (bus.move_valid) begin
                  r_player    <= ~r_player;
                  r_secs_left <= LIMIT4;
                  r_state     <= RUN;
                  r_warn      <= 1'b0;
                  r_rst_timer <= 1'b1;
               end else begin
                  r_rst_timer <= 1'b0;
                  if (w_tick) begin
                     r_secs_left <= w_secs_dec;
                     if ((r_state == RUN) && (w_secs_dec == WARN4)) begin
                        r_state <= WARN;
                        r_warn  <= 1'b1;
                     end else if ((r_state == WARN) && (w_secs_dec == 4'd0)) begin
                        r_state     <= EXPIRED;
                        r_warn      <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_rst_timer <= 1'b1;
                     end
                  end
               end
            end
            EXPIRED: begin
               // Restart hands the turn to the other player.
               if (bus.start) begin
                  r_state     <= RUN;
                  r_player    <= ~r_player;
                  r_secs_left <= LIMIT4;
                  r_rst_timer <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.rst_timer = r_rst_timer;
   assign bus.player    = r_player;
   assign bus.secs_left = r_secs_left;
   assign bus.warn      = r_warn;
   assign bus.timeout   = r_timeout;
   assign bus.state     = r_state;

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_turn_timer_ctrl
//   Bench for turn_timer_ctrl with an 8-bit free-running Timer model feeding
//   timer_in. A turn-level reference model (ticks consumed, active/expired)
//   predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_turn_timer_ctrl;
   localparam int LIMIT = 15;
   localparam int WARN  = 5;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   turn_timer_ctrl_if ifc ();

   turn_timer_ctrl #(.TURN_LIMIT(LIMIT), .WARN_AT(WARN)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream Timer: free-running, cleared while rst_timer is high.
   logic [7:0] tcnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)              tcnt <= 8'd0;
      else if (ifc.rst_timer)  tcnt <= 8'd0;
      else                     tcnt <= tcnt + 8'd1;
   end
   assign ifc.timer_in = tcnt;

   // Reference model: a turn is "active" with m_ticks ticks consumed.
   logic m_active, m_expired, m_player, m_rt, m_to;
   int   m_ticks;
   logic m_tick;
   assign m_tick = (tcnt == 8'hFF) && !m_rt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0; m_expired <= 1'b0; m_player <= 1'b0;
         m_ticks <= 0; m_rt <= 1'b1; m_to <= 1'b0;
      end else begin
         m_to <= 1'b0;
         if (!m_active) begin
            if (ifc.start) begin
               m_active <= 1'b1; m_ticks <= 0; m_rt <= 1'b0;
               if (m_expired) m_player <= ~m_player;
               m_expired <= 1'b0;
            end
         end else if (ifc.move_valid) begin
            m_player <= ~m_player; m_ticks <= 0; m_rt <= 1'b1;
         end else begin
            m_rt <= 1'b0;
            if (m_tick) begin
               if (m_ticks + 1 == LIMIT) begin
                  m_active <= 1'b0; m_expired <= 1'b1; m_to <= 1'b1;
                  m_rt <= 1'b1; m_ticks <= LIMIT;
               end else begin
                  m_ticks <= m_ticks + 1;
               end
            end
         end
      end
   end

   function automatic logic [9:0] dut_vec();
      return {ifc.state, ifc.rst_timer, ifc.player, ifc.secs_left, ifc.warn, ifc.timeout};
   endfunction

   function automatic logic [9:0] mdl_vec();
      logic [1:0] st;
      int left;
      left = LIMIT - m_ticks;
      if (!m_active)         st = m_expired ? 2'b11 : 2'b00;
      else if (left <= WARN) st = 2'b10;
      else                   st = 2'b01;
      return {st, m_rt, m_player, 4'(left), (st == 2'b10), m_to};
   endfunction

   localparam logic [9:0] RESET_VEC = {2'b00, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0};

   task automatic do_reset();
      rst_n = 1'b0; ifc.start = 1'b0; ifc.move_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ifc.start = 1'b0; ifc.move_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (dut_vec() !== RESET_VEC) begin
         errors++; $display("FAIL reset_vec got=%b exp=%b", dut_vec(), RESET_VEC);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (dut_vec() !== RESET_VEC) begin
         errors++; $display("FAIL idle_hold got=%b exp=%b", dut_vec(), RESET_VEC);
      end
   endtask

   task automatic test_countdown();
      do_reset();
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      checks++;
      if ({ifc.state, ifc.rst_timer, ifc.secs_left} !== {2'b01, 1'b0, 4'd15}) begin
         errors++; $display("FAIL start_run got=%b exp=%b", {ifc.state, ifc.rst_timer, ifc.secs_left}, 7'b0101111);
      end
      for (int n = 1; n <= 3842; n++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL countdown_model n=%0d got=%b exp=%b", n, dut_vec(), mdl_vec());
         end
         if (n == 255 || n == 256) begin
            checks++;
            if (ifc.secs_left !== ((n == 255) ? 4'd15 : 4'd14)) begin
               errors++; $display("FAIL first_tick n=%0d got=%0d exp=%0d", n, ifc.secs_left, (n == 255) ? 15 : 14);
            end
         end
         if (n == 2559 || n == 2560) begin
            checks++;
            if (ifc.state !== ((n == 2559) ? 2'b01 : 2'b10)) begin
               errors++; $display("FAIL warn_entry n=%0d got=%b exp=%b", n, ifc.state, (n == 2559) ? 2'b01 : 2'b10);
            end
         end
         if (n == 3840) begin
            checks++;
            if ({ifc.timeout, ifc.state, ifc.rst_timer, ifc.secs_left} !== {1'b1, 2'b11, 1'b1, 4'd0}) begin
               errors++; $display("FAIL expiry got=%b exp=%b", {ifc.timeout, ifc.state, ifc.rst_timer, ifc.secs_left}, 8'b11110000);
            end
         end
         if (n == 3841) begin
            checks++;
            if (ifc.timeout !== 1'b0) begin
               errors++; $display("FAIL timeout_width got=%b exp=0", ifc.timeout);
            end
         end
      end
   endtask

   task automatic test_move();
      do_reset();
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      for (int n = 1; n <= 2100; n++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL move_model n=%0d got=%b exp=%b", n, dut_vec(), mdl_vec());
         end
      end
      checks++;
      if (ifc.secs_left !== 4'd7) begin
         errors++; $display("FAIL move_pre_secs got=%0d exp=7", ifc.secs_left);
      end
      ifc.move_valid = 1'b1;
      @(negedge clk);
      ifc.move_valid = 1'b0;
      checks++;
      if ({ifc.state, ifc.player, ifc.secs_left, ifc.rst_timer} !== {2'b01, 1'b1, 4'd15, 1'b1}) begin
         errors++; $display("FAIL move_apply got=%b exp=%b", {ifc.state, ifc.player, ifc.secs_left, ifc.rst_timer}, 8'b01111111);
      end
      @(negedge clk);
      checks++;
      if ({ifc.rst_timer, ifc.timer_in} !== {1'b0, 8'h00}) begin
         errors++; $display("FAIL move_clear got=%b exp=%b", {ifc.rst_timer, ifc.timer_in}, 9'b0);
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin
         errors++; $display("FAIL move_post_model got=%b exp=%b", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_collision();
      logic p_before;
      int   n;
      n = 0;
      while (n < 4000 && !(ifc.state == 2'b10 && ifc.timer_in == 8'hFF)) begin
         @(negedge clk);
         n++;
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL collide_model n=%0d got=%b exp=%b", n, dut_vec(), mdl_vec());
         end
      end
      checks++;
      if (n >= 4000) begin
         errors++; $display("FAIL collide_wait got=timeout exp=warn_with_ff");
      end
      p_before = ifc.player;
      ifc.move_valid = 1'b1;
      @(negedge clk);
      ifc.move_valid = 1'b0;
      checks++;
      if ({ifc.state, ifc.secs_left, ifc.timeout, ifc.player} !== {2'b01, 4'd15, 1'b0, ~p_before}) begin
         errors++; $display("FAIL collide got=%b exp=%b", {ifc.state, ifc.secs_left, ifc.timeout, ifc.player}, {2'b01, 4'd15, 1'b0, ~p_before});
      end
   endtask

   task automatic test_async_reset();
      int n;
      n = 0;
      while (n < 4000 && ifc.state != 2'b10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ifc.state !== 2'b10) begin
         errors++; $display("FAIL areset_wait got=%b exp=10", ifc.state);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== RESET_VEC) begin
         errors++; $display("FAIL async_reset got=%b exp=%b", dut_vec(), RESET_VEC);
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin
         errors++; $display("FAIL async_reset_model got=%b exp=%b", dut_vec(), mdl_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_expired();
      do_reset();
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      for (int n = 1; n <= 3845; n++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL expire_model n=%0d got=%b exp=%b", n, dut_vec(), mdl_vec());
         end
      end
      ifc.move_valid = 1'b1;
      repeat (3) @(negedge clk);
      ifc.move_valid = 1'b0;
      checks++;
      if ({ifc.state, ifc.player, ifc.rst_timer, ifc.secs_left} !== {2'b11, 1'b0, 1'b1, 4'd0}) begin
         errors++; $display("FAIL expired_move got=%b exp=%b", {ifc.state, ifc.player, ifc.rst_timer, ifc.secs_left}, 8'b11010000);
      end
      ifc.start = 1'b1;
      @(negedge clk);
      checks++;
      if ({ifc.state, ifc.player, ifc.rst_timer, ifc.secs_left} !== {2'b01, 1'b1, 1'b0, 4'd15}) begin
         errors++; $display("FAIL expired_start got=%b exp=%b", {ifc.state, ifc.player, ifc.rst_timer, ifc.secs_left}, 8'b01101111);
      end
      // start held while running must not toggle the player again
      repeat (3) @(negedge clk);
      ifc.start = 1'b0;
      checks++;
      if ({ifc.state, ifc.player, ifc.secs_left} !== {2'b01, 1'b1, 4'd15}) begin
         errors++; $display("FAIL start_in_run got=%b exp=%b", {ifc.state, ifc.player, ifc.secs_left}, 7'b0111111);
      end
   endtask

   task automatic test_random();
      int unsigned rate;
      do_reset();
      for (int seg = 0; seg < 8; seg++) begin
         rate = (seg % 2 == 0) ? 300 : 6000;
         for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
               errors++; $display("FAIL random seg=%0d n=%0d got=%b exp=%b", seg, n, dut_vec(), mdl_vec());
            end
            ifc.start      = ($urandom_range(0, 49) == 0);
            ifc.move_valid = ($urandom_range(0, rate - 1) == 0) ||
                             (ifc.timer_in == 8'hFF && $urandom_range(0, 15) == 0);
         end
      end
      ifc.start = 1'b0;
      ifc.move_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      ifc.start = 1'b0;
      ifc.move_valid = 1'b0;
      test_reset();
      test_countdown();
      test_move();
      test_collision();
      test_async_reset();
      test_expired();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
